// File: rtl/mips_multicycle_control.sv
// Main control FSM for a multicycle MIPS datapath.
// Steps each instruction through fetch, decode, execute, memory and writeback.
// It drives the datapath mux selects, the write enables and the 2-bit ALUOp
// used by the ALU-function decoder. Memory accesses wait on mem_ready.
module mips_multicycle_control #(
    parameter logic [5:0] OP_RTYPE = 6'b000000,
    parameter logic [5:0] OP_LW    = 6'b100011,
    parameter logic [5:0] OP_SW    = 6'b101011,
    parameter logic [5:0] OP_BEQ   = 6'b000100,
    parameter logic [5:0] OP_ADDI  = 6'b001000,
    parameter logic [5:0] OP_J     = 6'b000010
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       Branch,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSrc,
    output logic [1:0] ALUOp,
    output logic [3:0] state,
    output logic       illegal_op
);

    // State encodings are visible on the debug port, so they are fixed.
    // Codes 12-15 are never entered from a legal path. If one is ever
    // reached, the FSM drives every output low and returns to FETCH.
    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    // ALU B operand selects
    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    // PC source selects
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // ALUOp codes for the function decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    state_t r_state;
    state_t w_next_state;
    logic   r_illegal_op;
    logic   w_set_illegal;

    // The opcode is decoded live from the instruction register.
    // IRWrite is low outside FETCH, so this value stays stable for the
    // whole instruction. MEMADR can therefore use it again to pick between
    // the read and write paths.
    logic w_is_rtype;
    logic w_is_lw;
    logic w_is_sw;
    logic w_is_beq;
    logic w_is_addi;
    logic w_is_j;

    assign w_is_rtype = (opcode == OP_RTYPE);
    assign w_is_lw    = (opcode == OP_LW);
    assign w_is_sw    = (opcode == OP_SW);
    assign w_is_beq   = (opcode == OP_BEQ);
    assign w_is_addi  = (opcode == OP_ADDI);
    assign w_is_j     = (opcode == OP_J);

    // State register and sticky illegal-opcode flag; reset wins over all transitions
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the values from before the edge. Blocking
        // assignments here would create order-dependent races.
        if (reset) begin
            r_state      <= S_FETCH;
            r_illegal_op <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_set_illegal) begin
                r_illegal_op <= 1'b1;
            end
        end
    end

    // Next-state selection and Moore outputs; FETCH gates IRWrite/PCWrite with mem_ready
    always_comb begin
        // NOTE: every signal driven in this block gets a default first.
        // Any state arm that leaves one out then falls back to 0 rather
        // than holding its old value, which would infer a latch.
        w_next_state  = S_FETCH;
        w_set_illegal = 1'b0;
        PCWrite       = 1'b0;
        Branch        = 1'b0;
        IorD          = 1'b0;
        MemWrite      = 1'b0;
        IRWrite       = 1'b0;
        MemtoReg      = 1'b0;
        RegDst        = 1'b0;
        RegWrite      = 1'b0;
        ALUSrcA       = 1'b0;
        ALUSrcB       = SRCB_REG;
        PCSrc         = PCSRC_ALU;
        ALUOp         = ALUOP_ADD;

        case (r_state)
            S_FETCH: begin
                // PC + 4 goes through the ALU. The IR and PC load only
                // once the instruction word is actually available.
                IorD    = 1'b0;
                ALUSrcA = 1'b0;
                ALUSrcB = SRCB_FOUR;
                ALUOp   = ALUOP_ADD;
                PCSrc   = PCSRC_ALU;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
                w_next_state = mem_ready ? S_DECODE : S_FETCH;
            end

            S_DECODE: begin
                // Compute the branch target speculatively while the opcode is decoded
                ALUSrcA = 1'b0;
                ALUSrcB = SRCB_IMM_SH;
                ALUOp   = ALUOP_ADD;
                if (w_is_lw || w_is_sw) begin
                    w_next_state = S_MEMADR;
                end else if (w_is_rtype) begin
                    w_next_state = S_EXECUTE;
                end else if (w_is_beq) begin
                    w_next_state = S_BRANCH;
                end else if (w_is_addi) begin
                    w_next_state = S_ADDIEX;
                end else if (w_is_j) begin
                    w_next_state = S_JUMP;
                end else begin
                    w_next_state  = S_FETCH;
                    w_set_illegal = 1'b1;
                end
            end

            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                ALUOp   = ALUOP_ADD;
                w_next_state = w_is_sw ? S_MEMWR : S_MEMRD;
            end

            S_MEMRD: begin
                IorD = 1'b1;
                w_next_state = mem_ready ? S_MEMWB : S_MEMRD;
            end

            S_MEMWB: begin
                RegDst   = 1'b0;
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
                w_next_state = S_FETCH;
            end

            S_MEMWR: begin
                // The write request stays asserted until memory accepts it
                IorD     = 1'b1;
                MemWrite = 1'b1;
                w_next_state = mem_ready ? S_FETCH : S_MEMWR;
            end

            S_EXECUTE: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_REG;
                ALUOp   = ALUOP_FUNCT;
                w_next_state = S_ALUWB;
            end

            S_ALUWB: begin
                RegDst   = 1'b1;
                MemtoReg = 1'b0;
                RegWrite = 1'b1;
                w_next_state = S_FETCH;
            end

            S_BRANCH: begin
                // Compare A and B by subtraction. The datapath qualifies
                // Branch with Zero to load the target computed in DECODE.
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_REG;
                ALUOp   = ALUOP_SUB;
                PCSrc   = PCSRC_ALUOUT;
                Branch  = 1'b1;
                w_next_state = S_FETCH;
            end

            S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                ALUOp   = ALUOP_ADD;
                w_next_state = S_ADDIWB;
            end

            S_ADDIWB: begin
                RegDst   = 1'b0;
                MemtoReg = 1'b0;
                RegWrite = 1'b1;
                w_next_state = S_FETCH;
            end

            S_JUMP: begin
                PCSrc   = PCSRC_JUMP;
                PCWrite = 1'b1;
                w_next_state = S_FETCH;
            end

            default: begin
                // Unused encodings: outputs stay at their zero defaults
                w_next_state = S_FETCH;
            end
        endcase
    end

    assign state      = r_state;
    assign illegal_op = r_illegal_op;

    // Structural invariants of the control word
    a_pc_branch_excl : assert property (@(posedge clk) disable iff (reset) !(PCWrite && Branch));
    a_reg_mem_excl   : assert property (@(posedge clk) disable iff (reset) !(RegWrite && MemWrite));
    a_irwrite_fetch  : assert property (@(posedge clk) disable iff (reset) IRWrite |-> (r_state == S_FETCH));

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Testbench for mips_multicycle_control.
// The driver applies inputs one cycle at a time and queues the state,
// control word and illegal_op flag expected for that cycle. A monitor
// takes each entry off the queue half a cycle later and compares it with
// the DUT.
module tb_mips_multicycle_control;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BAD   = 6'b111111;

    typedef struct packed {
        logic       pc_write;
        logic       branch;
        logic       iord;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic [1:0] alu_op;
    } ctrl_t;

    typedef struct {
        string      tag;
        logic [3:0] st;
        ctrl_t      ctrl;
        logic       ill;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       PCWrite, Branch, IorD, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, PCSrc, ALUOp;
    logic [3:0] state;
    logic       illegal_op;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    mips_multicycle_control dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .mem_ready  (mem_ready),
        .PCWrite    (PCWrite),
        .Branch     (Branch),
        .IorD       (IorD),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .MemtoReg   (MemtoReg),
        .RegDst     (RegDst),
        .RegWrite   (RegWrite),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .PCSrc      (PCSrc),
        .ALUOp      (ALUOp),
        .state      (state),
        .illegal_op (illegal_op)
    );

    always #5 clk = ~clk;

    ctrl_t obs_ctrl;
    assign obs_ctrl = {PCWrite, Branch, IorD, MemWrite, IRWrite, MemtoReg, RegDst,
                       RegWrite, ALUSrcA, ALUSrcB, PCSrc, ALUOp};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    // Control word expected in each state, taken from the state table
    function automatic ctrl_t exp_ctrl(input logic [3:0] st, input logic mr);
        ctrl_t c;
        c = '0;
        case (st)
            4'd0:  begin c.alu_src_b = 2'b01; c.ir_write = mr; c.pc_write = mr; end
            4'd1:  begin c.alu_src_b = 2'b11; end
            4'd2:  begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
            4'd3:  begin c.iord = 1'b1; end
            4'd4:  begin c.mem_to_reg = 1'b1; c.reg_write = 1'b1; end
            4'd5:  begin c.iord = 1'b1; c.mem_write = 1'b1; end
            4'd6:  begin c.alu_src_a = 1'b1; c.alu_op = 2'b10; end
            4'd7:  begin c.reg_dst = 1'b1; c.reg_write = 1'b1; end
            4'd8:  begin c.alu_src_a = 1'b1; c.alu_op = 2'b01; c.pc_src = 2'b01; c.branch = 1'b1; end
            4'd9:  begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
            4'd10: begin c.reg_write = 1'b1; end
            4'd11: begin c.pc_src = 2'b10; c.pc_write = 1'b1; end
            default: c = '0;
        endcase
        return c;
    endfunction

    // One cycle: drive inputs just after the edge and queue the expected
    // state and outputs for that cycle
    task automatic cyc(input string tag, input logic rst, input logic [5:0] op,
                       input logic mr, input logic [3:0] exp_st, input logic exp_ill);
        exp_t e;
        @(posedge clk);
        #1;
        reset     = rst;
        opcode    = op;
        mem_ready = mr;
        e.tag  = tag;
        e.st   = exp_st;
        e.ctrl = exp_ctrl(exp_st, mr);
        e.ill  = exp_ill;
        sb.push_back(e);
    endtask

    // Monitor: compares on the falling edge, away from the active edge
    always @(negedge clk) begin
        if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            check($sformatf("%s.state", e.tag), 32'(state), 32'(e.st));
            check($sformatf("%s.ctrl@%0d", e.tag, e.st), 32'(obs_ctrl), 32'(e.ctrl));
            check($sformatf("%s.illegal_op", e.tag), 32'(illegal_op), 32'(e.ill));
            check($sformatf("%s.pcw_and_br", e.tag), 32'(PCWrite & Branch), 32'd0);
            check($sformatf("%s.rw_and_mw", e.tag), 32'(RegWrite & MemWrite), 32'd0);
            check($sformatf("%s.irw_outside_fetch", e.tag),
                  32'(IRWrite & (state != 4'd0)), 32'd0);
        end
    end

    initial begin
        reset     = 1'b1;
        opcode    = OP_RTYPE;
        mem_ready = 1'b0;
        @(posedge clk);

        // Reset, then R-type add: 0,1,6,7,0
        cyc("rst",  1'b1, OP_RTYPE, 1'b1, 4'd0, 1'b0);
        cyc("add",  1'b0, OP_RTYPE, 1'b1, 4'd0, 1'b0);
        cyc("add",  1'b0, OP_RTYPE, 1'b1, 4'd1, 1'b0);
        cyc("add",  1'b0, OP_RTYPE, 1'b1, 4'd6, 1'b0);
        cyc("add",  1'b0, OP_RTYPE, 1'b1, 4'd7, 1'b0);

        // lw with 2 stall cycles in FETCH and 1 in MEMRD: 8 cycles
        cyc("lw",   1'b0, OP_LW, 1'b0, 4'd0, 1'b0);
        cyc("lw",   1'b0, OP_LW, 1'b0, 4'd0, 1'b0);
        cyc("lw",   1'b0, OP_LW, 1'b1, 4'd0, 1'b0);
        cyc("lw",   1'b0, OP_LW, 1'b1, 4'd1, 1'b0);
        cyc("lw",   1'b0, OP_LW, 1'b1, 4'd2, 1'b0);
        cyc("lw",   1'b0, OP_LW, 1'b0, 4'd3, 1'b0);
        cyc("lw",   1'b0, OP_LW, 1'b1, 4'd3, 1'b0);
        cyc("lw",   1'b0, OP_LW, 1'b1, 4'd4, 1'b0);

        // sw with 3 stall cycles in MEMWR: MemWrite held for 4 cycles
        cyc("sw",   1'b0, OP_SW, 1'b1, 4'd0, 1'b0);
        cyc("sw",   1'b0, OP_SW, 1'b1, 4'd1, 1'b0);
        cyc("sw",   1'b0, OP_SW, 1'b1, 4'd2, 1'b0);
        cyc("sw",   1'b0, OP_SW, 1'b0, 4'd5, 1'b0);
        cyc("sw",   1'b0, OP_SW, 1'b0, 4'd5, 1'b0);
        cyc("sw",   1'b0, OP_SW, 1'b0, 4'd5, 1'b0);
        cyc("sw",   1'b0, OP_SW, 1'b1, 4'd5, 1'b0);

        // beq then j, 3 cycles each
        cyc("beq",  1'b0, OP_BEQ, 1'b1, 4'd0, 1'b0);
        cyc("beq",  1'b0, OP_BEQ, 1'b1, 4'd1, 1'b0);
        cyc("beq",  1'b0, OP_BEQ, 1'b1, 4'd8, 1'b0);
        cyc("j",    1'b0, OP_J,   1'b1, 4'd0, 1'b0);
        cyc("j",    1'b0, OP_J,   1'b1, 4'd1, 1'b0);
        cyc("j",    1'b0, OP_J,   1'b1, 4'd11, 1'b0);

        // Illegal opcode sets the sticky flag; addi follows; reset clears it
        cyc("ill",  1'b0, OP_BAD,  1'b1, 4'd0, 1'b0);
        cyc("ill",  1'b0, OP_BAD,  1'b1, 4'd1, 1'b0);
        cyc("addi", 1'b0, OP_ADDI, 1'b1, 4'd0, 1'b1);
        cyc("addi", 1'b0, OP_ADDI, 1'b1, 4'd1, 1'b1);
        cyc("addi", 1'b0, OP_ADDI, 1'b1, 4'd9, 1'b1);
        cyc("addi", 1'b0, OP_ADDI, 1'b1, 4'd10, 1'b1);
        cyc("ill_rst", 1'b1, OP_ADDI, 1'b1, 4'd0, 1'b1);
        cyc("ill_clr", 1'b0, OP_SW,   1'b1, 4'd0, 1'b0);

        // Reset asserted while MEMWR is stalled
        cyc("mrst", 1'b0, OP_SW, 1'b1, 4'd1, 1'b0);
        cyc("mrst", 1'b0, OP_SW, 1'b1, 4'd2, 1'b0);
        cyc("mrst", 1'b1, OP_SW, 1'b0, 4'd5, 1'b0);
        cyc("mrst", 1'b1, OP_SW, 1'b0, 4'd0, 1'b0);
        cyc("mrst", 1'b1, OP_SW, 1'b0, 4'd0, 1'b0);
        cyc("post", 1'b0, OP_RTYPE, 1'b1, 4'd0, 1'b0);
        cyc("post", 1'b0, OP_RTYPE, 1'b1, 4'd1, 1'b0);

        // Let the monitor drain the scoreboard
        @(posedge clk);
        repeat (2) @(negedge clk);
        check("sb_drain", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
